// File: rtl/vga_pkg.sv
// Shared types and defaults for the text overlay path.
//   wr_cmd_e   : command encoding on the character buffer write port
//   state_e    : character buffer controller states
//   TEXT_COLS / TEXT_ROWS / CLEAR_CHAR : default grid geometry and fill code
package vga_pkg;

  typedef enum logic [1:0] {
    CMD_CHAR    = 2'd0,
    CMD_NEWLINE = 2'd1,
    CMD_SETCUR  = 2'd2,
    CMD_CLEAR   = 2'd3
  } wr_cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int         TEXT_COLS  = 16;
  localparam int         TEXT_ROWS  = 16;
  localparam logic [6:0] CLEAR_CHAR = 7'h20;

endpackage

// File: rtl/text_ram.sv
// 256x7 simple dual-port RAM holding the character grid.
//   i_clk          : clock
//   i_we/i_waddr/i_wdata : synchronous write port
//   i_raddr/o_rdata      : synchronous read port, read-first on collision
// No reset so it maps onto block RAM.
module text_ram (
  input  logic       i_clk,
  input  logic       i_we,
  input  logic [7:0] i_waddr,
  input  logic [6:0] i_wdata,
  input  logic [7:0] i_raddr,
  output logic [6:0] o_rdata
);

  logic [6:0] r_mem [256];

  // Both updates are non-blocking, so a same-address read sees the old word.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/char_text_buffer.sv
// Character-cell text memory for the text overlay.
//   clk, rst          : pixel clock, async active-high reset
//   char_xy/char_code : read cell {row,col}, code returned one cycle later
//   wr_valid/wr_ready : command handshake; wr_cmd/wr_data carry the command
//   cursor            : write cursor {row,col}
//   busy              : self-clear in progress (after reset or CMD_CLEAR)
module char_text_buffer
  import vga_pkg::*;
#(
  parameter int         COLS       = TEXT_COLS,
  parameter int         ROWS       = TEXT_ROWS,
  parameter logic [6:0] CLEAR_CHAR = vga_pkg::CLEAR_CHAR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_cmd,
  input  logic [7:0] wr_data,
  output logic [7:0] cursor,
  output logic       busy
);

  localparam logic [3:0] LAST_COL = 4'(COLS - 1);
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  state_e     r_state;
  logic [7:0] r_clr_cnt;
  logic [7:0] r_cursor;
  logic       r_busy;
  logic       r_ready;
  logic       r_rd_vld;
  logic       r_rd_oor;

  logic       w_accept;
  wr_cmd_e    w_cmd;
  logic [3:0] w_col, w_row, w_next_row, w_set_col, w_set_row;
  logic       w_we;
  logic [7:0] w_waddr;
  logic [6:0] w_wdata;
  logic [6:0] w_ram_q;

  assign w_accept   = wr_valid & r_ready;
  assign w_cmd      = wr_cmd_e'(wr_cmd);
  assign w_col      = r_cursor[3:0];
  assign w_row      = r_cursor[7:4];
  assign w_next_row = (w_row == LAST_ROW) ? 4'd0 : w_row + 4'd1;
  // Clamp SETCUR fields to the visible grid (8-bit compare avoids a
  // degenerate constant comparison at the 16x16 default).
  assign w_set_col  = ({4'd0, wr_data[3:0]} >= 8'(COLS)) ? LAST_COL : wr_data[3:0];
  assign w_set_row  = ({4'd0, wr_data[7:4]} >= 8'(ROWS)) ? LAST_ROW : wr_data[7:4];

  // Single RAM write port shared by the clear sweep and CMD_CHAR.
  // The cursor is always inside the visible grid, so CMD_CHAR never
  // lands on an out-of-range cell.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_clr_cnt;
    w_wdata = CLEAR_CHAR;
    if (r_state == ST_CLEAR) begin
      w_we = 1'b1;
    end else if (w_accept && w_cmd == CMD_CHAR) begin
      w_we    = 1'b1;
      w_waddr = r_cursor;
      w_wdata = wr_data[6:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= 8'd0;
      r_cursor  <= 8'd0;
      r_busy    <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 8'd1;
          if (r_clr_cnt == 8'hFF) begin
            r_state  <= ST_IDLE;
            r_cursor <= 8'd0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
          end
        end
        default: begin
          if (w_accept) begin
            case (w_cmd)
              CMD_CHAR: begin
                if (w_col == LAST_COL) r_cursor <= {w_next_row, 4'd0};
                else                   r_cursor <= {w_row, w_col + 4'd1};
              end
              CMD_NEWLINE: r_cursor <= {w_next_row, 4'd0};
              CMD_SETCUR:  r_cursor <= {w_set_row, w_set_col};
              default: begin
                r_state   <= ST_CLEAR;
                r_clr_cnt <= 8'd0;
                r_busy    <= 1'b1;
                r_ready   <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  // The RAM output register has no reset; these flags supply the reset
  // value of char_code and the out-of-range mask in the same read cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld <= 1'b0;
      r_rd_oor <= 1'b0;
    end else begin
      r_rd_vld <= 1'b1;
      r_rd_oor <= ({4'd0, char_xy[3:0]} >= 8'(COLS)) ||
                  ({4'd0, char_xy[7:4]} >= 8'(ROWS));
    end
  end

  text_ram u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (char_xy),
    .o_rdata (w_ram_q)
  );

  assign char_code = !r_rd_vld ? 7'd0 : (r_rd_oor ? CLEAR_CHAR : w_ram_q);
  assign wr_ready  = r_ready;
  assign cursor    = r_cursor;
  assign busy      = r_busy;

endmodule

// File: tb/tb_char_text_buffer.sv
// Bench for char_text_buffer: instance 0 uses the 16x16 default grid,
// instance 1 a 10x4 grid. A cell-array reference model tracks both.
module tb_char_text_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] xy [2];
  logic       vld [2];
  logic [1:0] cmd [2];
  logic [7:0] dat [2];
  logic [6:0] code [2];
  logic       rdy [2];
  logic       bsy [2];
  logic [7:0] cur [2];

  int n_cmp = 0;
  int n_err = 0;

  // reference model
  int         m_cols [2] = '{16, 10};
  int         m_rows [2] = '{16, 4};
  logic [6:0] m_mem [2][256];
  int         m_row [2], m_col [2];
  int         m_clr [2];     // clear cycles still to run; 0 = idle
  logic [6:0] e_code [2];

  always #5 clk = ~clk;

  char_text_buffer dut0 (
    .clk(clk), .rst(rst), .char_xy(xy[0]), .char_code(code[0]),
    .wr_valid(vld[0]), .wr_ready(rdy[0]), .wr_cmd(cmd[0]), .wr_data(dat[0]),
    .cursor(cur[0]), .busy(bsy[0]));

  char_text_buffer #(.COLS(10), .ROWS(4)) dut1 (
    .clk(clk), .rst(rst), .char_xy(xy[1]), .char_code(code[1]),
    .wr_valid(vld[1]), .wr_ready(rdy[1]), .wr_cmd(cmd[1]), .wr_data(dat[1]),
    .cursor(cur[1]), .busy(bsy[1]));

  function automatic logic [7:0] m_cur(int i);
    return {4'(m_row[i]), 4'(m_col[i])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_clr[i] = 256; m_row[i] = 0; m_col[i] = 0; e_code[i] = 7'd0;
    end
  endtask

  // Apply the inputs to the model, clock once, sample #1 after the edge.
  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      int r, c;
      r = int'(xy[i][7:4]); c = int'(xy[i][3:0]);
      e_code[i] = (r >= m_rows[i] || c >= m_cols[i]) ? 7'h20 : m_mem[i][xy[i]];
      if (m_clr[i] > 0) begin
        m_mem[i][256 - m_clr[i]] = 7'h20;
        m_clr[i]--;
        if (m_clr[i] == 0) begin m_row[i] = 0; m_col[i] = 0; end
      end else if (vld[i]) begin
        case (cmd[i])
          2'd0: begin
            m_mem[i][m_row[i]*16 + m_col[i]] = dat[i][6:0];
            m_col[i]++;
            if (m_col[i] == m_cols[i]) begin
              m_col[i] = 0;
              m_row[i] = (m_row[i] + 1) % m_rows[i];
            end
          end
          2'd1: begin m_col[i] = 0; m_row[i] = (m_row[i] + 1) % m_rows[i]; end
          2'd2: begin
            m_col[i] = (int'(dat[i][3:0]) < m_cols[i]) ? int'(dat[i][3:0]) : m_cols[i] - 1;
            m_row[i] = (int'(dat[i][7:4]) < m_rows[i]) ? int'(dat[i][7:4]) : m_rows[i] - 1;
          end
          default: m_clr[i] = 256;
        endcase
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send(int i, logic [1:0] c, logic [7:0] d);
    vld[i] = 1'b1; cmd[i] = c; dat[i] = d;
    tick();
    vld[i] = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (code[i] !== 7'd0 || cur[i] !== 8'd0 || bsy[i] !== 1'b1 || rdy[i] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_values[%0d]: code=%h cur=%h busy=%b ready=%b want 00 00 1 0",
                 i, code[i], cur[i], bsy[i], rdy[i]);
      end
    end
    rst = 1'b0;
    n = 0;
    while (bsy[0] === 1'b1 && n < 400) begin tick(); n++; end
    n_cmp++;
    if (n !== 256) begin
      n_err++; $display("FAIL reset_clear_len: got %0d cycles want 256", n);
    end
    n_cmp++;
    if (rdy[0] !== 1'b1 || cur[0] !== 8'h00 || rdy[1] !== 1'b1) begin
      n_err++; $display("FAIL reset_idle: ready=%b/%b cursor=%h want 1/1 00", rdy[0], rdy[1], cur[0]);
    end
    for (int a = 0; a < 256; a++) begin
      xy[0] = 8'(a);
      tick();
      n_cmp++;
      if (code[0] !== 7'h20) begin
        n_err++; $display("FAIL sweep_clear: xy=%h code=%h want 20", a[7:0], code[0]);
      end
    end
  endtask

  task automatic test_write();
    xy[0] = 8'h00;
    send(0, 2'd0, 8'h41);
    n_cmp++;
    if (cur[0] !== 8'h01) begin
      n_err++; $display("FAIL write_cursor: got %h want 01", cur[0]);
    end
    tick();
    n_cmp++;
    if (code[0] !== 7'h41) begin
      n_err++; $display("FAIL write_read: got %h want 41", code[0]);
    end
  endtask

  task automatic test_row_wrap();
    send(0, 2'd2, 8'h0F);
    send(0, 2'd0, 8'h31);
    n_cmp++;
    if (cur[0] !== 8'h10) begin
      n_err++; $display("FAIL row_wrap: got %h want 10", cur[0]);
    end
    send(0, 2'd2, 8'hFF);
    send(0, 2'd0, 8'h32);
    n_cmp++;
    if (cur[0] !== 8'h00) begin
      n_err++; $display("FAIL grid_wrap: got %h want 00", cur[0]);
    end
  endtask

  task automatic test_newline();
    for (int i = 0; i < 2; i++) begin vld[i] = 1'b1; cmd[i] = 2'd2; dat[i] = 8'h35; end
    tick();
    for (int i = 0; i < 2; i++) cmd[i] = 2'd1;
    tick();
    for (int i = 0; i < 2; i++) vld[i] = 1'b0;
    n_cmp++;
    if (cur[0] !== 8'h40) begin
      n_err++; $display("FAIL newline: got %h want 40", cur[0]);
    end
    n_cmp++;
    if (cur[1] !== 8'h00) begin
      n_err++; $display("FAIL newline_wrap_rows4: got %h want 00", cur[1]);
    end
  endtask

  task automatic test_clear_handshake();
    int n;
    send(0, 2'd3, 8'h00);
    vld[0] = 1'b1; cmd[0] = 2'd0; dat[0] = 8'h42;
    n = 0;
    while (rdy[0] !== 1'b1 && n < 400) begin tick(); n++; end
    n_cmp++;
    if (n !== 256 || cur[0] !== 8'h00) begin
      n_err++; $display("FAIL clear_stall: stalled %0d cycles cursor=%h want 256 00", n, cur[0]);
    end
    tick();
    vld[0] = 1'b0; xy[0] = 8'h00;
    tick();
    n_cmp++;
    if (code[0] !== 7'h42 || cur[0] !== 8'h01) begin
      n_err++; $display("FAIL clear_then_write: code=%h cursor=%h want 42 01", code[0], cur[0]);
    end
  endtask

  task automatic test_read_write_same();
    xy[0] = 8'h01;
    send(0, 2'd0, 8'h55);
    n_cmp++;
    if (code[0] !== 7'h20) begin
      n_err++; $display("FAIL read_first: got %h want 20", code[0]);
    end
    tick();
    n_cmp++;
    if (code[0] !== 7'h55) begin
      n_err++; $display("FAIL read_after_write: got %h want 55", code[0]);
    end
  endtask

  task automatic test_oor_read();
    xy[1] = 8'h0C;
    tick();
    n_cmp++;
    if (code[1] !== 7'h20) begin
      n_err++; $display("FAIL oor_col: got %h want 20", code[1]);
    end
    xy[1] = 8'h52;
    tick();
    n_cmp++;
    if (code[1] !== 7'h20) begin
      n_err++; $display("FAIL oor_row: got %h want 20", code[1]);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    send(0, 2'd3, 8'h00);
    repeat (100) tick();
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (bsy[0] !== 1'b1 || rdy[0] !== 1'b0 || cur[0] !== 8'h00 || code[0] !== 7'd0) begin
      n_err++; $display("FAIL reset_abort: busy=%b ready=%b cursor=%h code=%h", bsy[0], rdy[0], cur[0], code[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    while (bsy[0] === 1'b1 && n < 400) begin tick(); n++; end
    n_cmp++;
    if (n !== 256 || rdy[0] !== 1'b1) begin
      n_err++; $display("FAIL restart_clear: got %0d cycles ready=%b want 256 1", n, rdy[0]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 2; i++) begin
        int r;
        r = int'($urandom_range(0, 63));
        vld[i] = ($urandom_range(0, 3) != 0);
        cmd[i] = (r == 0) ? 2'd3 : 2'(r % 3);
        dat[i] = 8'($urandom);
        xy[i]  = 8'($urandom);
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (cur[i] !== m_cur(i) || rdy[i] !== (m_clr[i] == 0) || bsy[i] !== (m_clr[i] != 0)) begin
          n_err++;
          $display("FAIL rand_ctrl[%0d] cyc %0d: cursor=%h ready=%b busy=%b want %h %b %b",
                   i, k, cur[i], rdy[i], bsy[i], m_cur(i), m_clr[i] == 0, m_clr[i] != 0);
        end
        if (!$isunknown(e_code[i])) begin
          n_cmp++;
          if (code[i] !== e_code[i]) begin
            n_err++; $display("FAIL rand_code[%0d] cyc %0d: got %h want %h", i, k, code[i], e_code[i]);
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) vld[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      xy[i] = 8'h00; vld[i] = 1'b0; cmd[i] = 2'd0; dat[i] = 8'h00;
      for (int a = 0; a < 256; a++) m_mem[i][a] = 'x;
    end
    test_reset();
    test_write();
    test_row_wrap();
    test_newline();
    test_clear_handshake();
    test_read_write_same();
    test_oor_read();
    test_reset_mid_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
